// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, majority-vote bit sampling,
// deserialisation, parity/stop checking, registered byte and error strobes.
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   state_t state, nxt;

   logic [5:0]            p_q;
   logic                  pe_q;
   logic                  pt_q;
   logic [5:0]            edge_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [1:0]            smp;
   logic                  bit_q;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_bad;

   logic [5:0] half;
   logic       bit_end;
   logic       smp_early;
   logic       smp_mid;
   logic       maj;

   logic vld_d, perr_d, serr_d;
   logic vld_p, perr_p, serr_p;

   assign half      = {1'b0, p_q[5:1]};
   assign bit_end   = (edge_cnt == p_q - 6'd1);
   assign smp_early = (edge_cnt == half - 6'd2) || (edge_cnt == half - 6'd1);
   assign smp_mid   = (edge_cnt == half);
   assign maj       = (smp[1] & smp[0]) | (smp[1] & RX_IN) | (smp[0] & RX_IN);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:   if (!RX_IN) nxt = START;
         START:  if (bit_end) nxt = bit_q ? IDLE : DATA;
         DATA:   if (bit_end && bit_cnt == LAST) nxt = pe_q ? PARITY : STOP;
         PARITY: if (bit_end) nxt = STOP;
         STOP:   if (bit_end) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Stop-bit failure and parity failure are reported independently
   always_comb begin
      vld_d  = 1'b0;
      perr_d = 1'b0;
      serr_d = 1'b0;
      if (state == STOP && bit_end) begin
         serr_d = ~bit_q;
         perr_d = par_bad;
         vld_d  = bit_q & ~par_bad;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         p_q        <= '0;
         pe_q       <= 1'b0;
         pt_q       <= 1'b0;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         smp        <= '0;
         bit_q      <= 1'b1;
         shreg      <= '0;
         par_bad    <= 1'b0;
         vld_p      <= 1'b0;
         perr_p     <= 1'b0;
         serr_p     <= 1'b0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         if (state == IDLE) begin
            edge_cnt <= '0;
            if (!RX_IN) begin
               p_q     <= Prescale;
               pe_q    <= PAR_EN;
               pt_q    <= PAR_TYP;
               par_bad <= 1'b0;
            end
         end else if (bit_end) begin
            edge_cnt <= '0;
         end else begin
            edge_cnt <= edge_cnt + 6'd1;
         end

         if (state != DATA)
            bit_cnt <= '0;
         else if (bit_end)
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;

         if (state != IDLE) begin
            if (smp_early) smp <= {smp[0], RX_IN};
            if (smp_mid)   bit_q <= maj;
         end

         if (state == DATA && bit_end)
            shreg <= {bit_q, shreg[DATA_WIDTH-1:1]};

         if (state == PARITY && bit_end)
            par_bad <= bit_q ^ (^shreg) ^ pt_q;

         vld_p      <= vld_d;
         perr_p     <= perr_d;
         serr_p     <= serr_d;
         data_valid <= vld_p;
         par_err    <= perr_p;
         stp_err    <= serr_p;
         if (vld_p) P_DATA <= shreg;
      end
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frames, parity/stop errors,
// glitch rejection, majority vote and mid-frame reset.
module tb_uart_rx_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int n_cmp = 0;
   int n_bad = 0;
   int n_strobe = 0;

   uart_rx_fsm #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK)
      if (data_valid | par_err | stp_err) n_strobe++;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one frame, each bit for p clocks; cycle 0 is the first edge
   // that sees the start bit. Cycle 'flip' gets RX_IN inverted.
   task automatic frame(input logic [7:0] d, input int p, input bit pe,
                        input bit pt, input bit pbit, input bit sbit,
                        input int flip, input int ncyc);
      logic [10:0] bits;
      int nb;
      nb = 10 + int'(pe);
      bits = '0;
      bits[8:1] = d;
      if (pe) begin
         bits[9]  = pbit;
         bits[10] = sbit;
      end else begin
         bits[9]  = sbit;
      end
      Prescale = 6'(p);
      PAR_EN   = pe;
      PAR_TYP  = pt;
      for (int n = 0; n < nb * p && n < ncyc; n++) begin
         if (n == 2) begin
            Prescale = (p == 8) ? 6'd16 : 6'd8;
            PAR_EN   = ~pe;
            PAR_TYP  = ~pt;
         end
         RX_IN = bits[4'(n / p)] ^ (n == flip);
         @(posedge CLK); #1;
      end
      RX_IN = 1'b1;
   endtask

   // Called right after frame(): next edge is cycle F, strobe at F+1.
   task automatic expect_out(input string tag, input bit dv, input bit pe,
                             input bit se, input logic [7:0] pd,
                             input bit post);
      @(posedge CLK); #1;
      check({tag, "_early"}, {29'd0, data_valid, par_err, stp_err}, 0);
      @(posedge CLK); #1;
      check({tag, "_dv"}, data_valid, dv);
      check({tag, "_par"}, par_err, pe);
      check({tag, "_stp"}, stp_err, se);
      check({tag, "_pdata"}, P_DATA, pd);
      if (post) begin
         @(posedge CLK); #1;
         check({tag, "_late"}, {29'd0, data_valid, par_err, stp_err}, 0);
      end
   endtask

   int s;

   initial begin
      RST      = 1'b1;
      RX_IN    = 1'b1;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      Prescale = 6'd8;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_pdata", P_DATA, 0);
      check("rst_dv", data_valid, 0);
      check("rst_par", par_err, 0);
      check("rst_stp", stp_err, 0);
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;

      frame(8'hA5, 8, 0, 0, 0, 1, -1, 10000);
      expect_out("a5_p8", 1, 0, 0, 8'hA5, 0);

      frame(8'h3C, 16, 1, 0, 0, 1, -1, 10000);
      expect_out("3c_even_ok", 1, 0, 0, 8'h3C, 1);

      frame(8'h3C, 16, 1, 0, 1, 1, -1, 10000);
      expect_out("3c_even_bad", 0, 1, 0, 8'h3C, 1);

      frame(8'h01, 32, 1, 1, 1, 0, -1, 10000);
      expect_out("01_odd_both", 0, 1, 1, 8'h3C, 1);

      frame(8'h01, 32, 1, 1, 0, 0, -1, 10000);
      expect_out("01_odd_stp", 0, 0, 1, 8'h3C, 1);

      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      s = n_strobe;
      RX_IN = 1'b0;
      repeat (2) begin
         @(posedge CLK); #1;
      end
      RX_IN = 1'b1;
      repeat (20) begin
         @(posedge CLK); #1;
      end
      check("glitch_none", n_strobe - s, 0);

      frame(8'h55, 8, 0, 0, 0, 1, -1, 10000);
      expect_out("55_after_glitch", 1, 0, 0, 8'h55, 1);

      frame(8'hFF, 8, 0, 0, 0, 1, 4 * 8 + 4, 10000);
      expect_out("ff_majority", 1, 0, 0, 8'hFF, 1);

      frame(8'h12, 8, 0, 0, 0, 1, -1, 3 * 8 + 3);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("midrst_pdata", P_DATA, 0);
      check("midrst_dv", data_valid, 0);
      s = n_strobe;
      repeat (100) begin
         @(posedge CLK); #1;
      end
      check("midrst_none", n_strobe - s, 0);

      frame(8'h34, 8, 0, 0, 0, 1, -1, 10000);
      expect_out("34_after_rst", 1, 0, 0, 8'h34, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
